// File: rtl/gpr_pkg.sv
// Shared register-file constants and the write-request record used by the
// write-back arbiter and its result buffer.
package gpr_pkg;
  localparam int REG_W  = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_W-1:0] R0 = '0;

  // One pending register-file write: destination and value.
  typedef struct packed {
    logic [REG_W-1:0]  sel;
    logic [DATA_W-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Result buffer for long-latency (mul/div) writes.
// DEPTH-entry ring with a head pointer and per-entry valid bits. The tail is
// head + count, so a head/tail collision is resolved by the count.
// Entries whose sel matches i_sq_sel are squashed. Survivors are re-packed
// behind the head on every edge, so no holes remain and a squash never costs
// a write slot.
// Ports:
//   i_clk, i_rst_n             clock, async active-low reset
//   i_push/i_push_sel/data     append at tail (caller guarantees not full)
//   i_pop                      drop the head (caller guarantees head valid)
//   i_sq_en/i_sq_sel           invalidate every entry with this sel
//   o_head_vld/sel/data        oldest valid entry
//   o_count                    number of valid entries
module wb_fifo
  import gpr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [REG_W-1:0]  i_push_sel,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic              i_sq_en,
  input  logic [REG_W-1:0]  i_sq_sel,
  output logic              o_head_vld,
  output logic [REG_W-1:0]  o_head_sel,
  output logic [DATA_W-1:0] o_head_data,
  output logic [2:0]        o_count
);
  localparam int PW = $clog2(DEPTH);

  wb_req_t          r_ent [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [PW-1:0]    r_head;
  logic [2:0]       r_cnt;

  wb_req_t          w_lst     [DEPTH];   // survivors in logical (age) order
  wb_req_t          w_ent_nxt [DEPTH];
  logic [DEPTH-1:0] w_vld_nxt;
  logic [PW-1:0]    w_head_nxt;
  logic [PW-1:0]    w_phys;
  logic [2:0]       w_n;

  always_comb begin
    w_n        = '0;
    w_phys     = '0;
    w_vld_nxt  = '0;
    w_head_nxt = r_head + PW'(i_pop);
    for (int j = 0; j < DEPTH; j++) begin
      w_lst[j]     = '0;
      w_ent_nxt[j] = '0;
    end
    // Walk from the head, keeping entries that are neither popped nor squashed.
    for (int k = 0; k < DEPTH; k++) begin
      w_phys = r_head + PW'(k);
      if (r_vld[w_phys] && !(i_sq_en && r_ent[w_phys].sel == i_sq_sel) &&
          !(i_pop && k == 0)) begin
        w_lst[w_n[PW-1:0]] = r_ent[w_phys];
        w_n = w_n + 3'd1;
      end
    end
    if (i_push) begin
      w_lst[w_n[PW-1:0]] = '{sel: i_push_sel, data: i_push_data};
      w_n = w_n + 3'd1;
    end
    // Lay the survivors back down contiguously from the new head.
    for (int j = 0; j < DEPTH; j++) begin
      w_phys            = w_head_nxt + PW'(j);
      w_ent_nxt[w_phys] = w_lst[j];
      w_vld_nxt[w_phys] = (3'(j) < w_n);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_vld  <= '0;
      r_head <= '0;
      r_cnt  <= '0;
      for (int j = 0; j < DEPTH; j++) r_ent[j] <= '0;
    end else begin
      r_vld  <= w_vld_nxt;
      r_head <= w_head_nxt;
      r_cnt  <= w_n;
      for (int j = 0; j < DEPTH; j++) r_ent[j] <= w_ent_nxt[j];
    end
  end

  assign o_head_vld  = r_vld[r_head];
  assign o_head_sel  = r_ent[r_head].sel;
  assign o_head_data = r_ent[r_head].data;
  assign o_count     = r_cnt;
endmodule

// File: rtl/wb_write_arbiter.sv
// Register-file write-back arbiter.
// The in-order ALU result cannot stall, so it always wins. Mul/div results
// issue directly when the buffer is empty and the port is free. Otherwise
// they wait in wb_fifo. An ALU write to X kills any older pending write to X.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   alu_valid/alu_sel/alu_data      unstallable ALU result
//   md_valid/md_sel/md_data         mul/div offer, md_ready handshake
//   WE/WeSel/WData                  registered register-file write port
//   buf_count                       buffered mul/div entries
module wb_write_arbiter
  import gpr_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [REG_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              md_valid,
  input  logic [REG_W-1:0]  md_sel,
  input  logic [DATA_W-1:0] md_data,
  output logic              md_ready,
  output logic              WE,
  output logic [REG_W-1:0]  WeSel,
  output logic [DATA_W-1:0] WData,
  output logic [2:0]        buf_count
);
  logic              w_head_vld;
  logic [REG_W-1:0]  w_head_sel;
  logic [DATA_W-1:0] w_head_data;
  logic [2:0]        w_cnt;
  logic              w_alu_wr, w_md_xfer, w_md_kill, w_bypass, w_push, w_pop;
  logic              w_sel_any;
  logic [REG_W-1:0]  w_sel_sel;
  logic [DATA_W-1:0] w_sel_data;

  // Depends only on buffer occupancy, never on md_valid.
  assign md_ready  = rst_n && (w_cnt < 3'(DEPTH));
  assign w_alu_wr  = alu_valid && (alu_sel != R0);
  assign w_md_xfer = md_valid && md_ready;
  // R0 writes are accepted and dropped; a same-edge ALU write supersedes md.
  assign w_md_kill = w_md_xfer && ((md_sel == R0) || (w_alu_wr && md_sel == alu_sel));
  assign w_bypass  = w_md_xfer && !w_md_kill && !w_alu_wr && !w_head_vld;
  assign w_push    = w_md_xfer && !w_md_kill && !w_bypass;
  assign w_pop     = !w_alu_wr && w_head_vld;

  always_comb begin
    w_sel_any  = 1'b0;
    w_sel_sel  = '0;
    w_sel_data = '0;
    if (w_alu_wr) begin
      w_sel_any  = 1'b1;
      w_sel_sel  = alu_sel;
      w_sel_data = alu_data;
    end else if (w_head_vld) begin
      w_sel_any  = 1'b1;
      w_sel_sel  = w_head_sel;
      w_sel_data = w_head_data;
    end else if (w_bypass) begin
      w_sel_any  = 1'b1;
      w_sel_sel  = md_sel;
      w_sel_data = md_data;
    end
  end

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_push      (w_push),
    .i_push_sel  (md_sel),
    .i_push_data (md_data),
    .i_pop       (w_pop),
    .i_sq_en     (w_alu_wr),
    .i_sq_sel    (alu_sel),
    .o_head_vld  (w_head_vld),
    .o_head_sel  (w_head_sel),
    .o_head_data (w_head_data),
    .o_count     (w_cnt)
  );

  // Select/data hold when idle so the register file sees a quiet bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE    <= 1'b0;
      WeSel <= '0;
      WData <= '0;
    end else begin
      WE <= w_sel_any;
      if (w_sel_any) begin
        WeSel <= w_sel_sel;
        WData <= w_sel_data;
      end
    end
  end

  assign buf_count = w_cnt;
endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;
  import gpr_pkg::*;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, md_valid = 1'b0;
  logic [4:0]  alu_sel = '0, md_sel = '0;
  logic [31:0] alu_data = '0, md_data = '0;
  logic        md_ready, WE;
  logic [4:0]  WeSel;
  logic [31:0] WData;
  logic [2:0]  buf_count;

  always #5 clk = ~clk;

  wb_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_sel(alu_sel), .alu_data(alu_data),
    .md_valid(md_valid), .md_sel(md_sel), .md_data(md_data),
    .md_ready(md_ready), .WE(WE), .WeSel(WeSel), .WData(WData),
    .buf_count(buf_count)
  );

  int n_err = 0, n_chk = 0;

  // Reference model: pending mul/div writes as an ordered queue.
  wb_req_t     mq[$];
  logic        e_we = 1'b0;
  logic [4:0]  e_sel = '0;
  logic [31:0] e_data = '0;
  logic        got_rdy;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock: apply inputs, check md_ready, advance model, check outputs.
  task automatic cyc(input logic av, input logic [4:0] as, input logic [31:0] ad,
                     input logic mv, input logic [4:0] ms, input logic [31:0] mdd);
    logic    rdy, empty, aw;
    wb_req_t nq[$];
    alu_valid = av; alu_sel = as; alu_data = ad;
    md_valid = mv; md_sel = ms; md_data = mdd;
    #1;
    rdy     = (mq.size() < DEPTH);
    got_rdy = md_ready;
    chk("md_ready", {31'd0, md_ready}, {31'd0, rdy});
    empty = (mq.size() == 0);
    aw    = av && (as != 5'd0);
    e_we  = 1'b0;
    if (aw) begin
      e_we = 1'b1; e_sel = as; e_data = ad;
      foreach (mq[i]) if (mq[i].sel != as) nq.push_back(mq[i]);
      mq = nq;
    end else if (!empty) begin
      e_we = 1'b1; e_sel = mq[0].sel; e_data = mq[0].data;
      void'(mq.pop_front());
    end
    if (mv && rdy && ms != 5'd0 && !(aw && ms == as)) begin
      if (!aw && empty) begin
        e_we = 1'b1; e_sel = ms; e_data = mdd;
      end else begin
        mq.push_back('{sel: ms, data: mdd});
      end
    end
    @(posedge clk); #1;
    chk("WE", {31'd0, WE}, {31'd0, e_we});
    chk("WeSel", {27'd0, WeSel}, {27'd0, e_sel});
    chk("WData", WData, e_data);
    chk("buf_count", {29'd0, buf_count}, mq.size());
  endtask

  typedef struct {
    logic av; logic [4:0] as; logic [31:0] ad;
    logic mv; logic [4:0] ms; logic [31:0] md;
    logic rdy; logic we; logic [4:0] sel; logic [31:0] data; logic [2:0] cnt;
  } vec_t;
  vec_t tv[19];

  initial begin
    // Directed vectors: inputs, md_ready before the edge, outputs after it.
    tv[0]  = '{1, 5,  32'h11,  0, 0,  32'h0,  1, 1, 5,  32'h11,  3'd0};
    tv[1]  = '{1, 3,  32'h33,  1, 7,  32'hAA, 1, 1, 3,  32'h33,  3'd1};
    tv[2]  = '{0, 0,  32'h0,   0, 0,  32'h0,  1, 1, 7,  32'hAA,  3'd0};
    tv[3]  = '{0, 0,  32'h0,   0, 0,  32'h0,  1, 0, 7,  32'hAA,  3'd0};
    tv[4]  = '{1, 1,  32'h101, 1, 10, 32'hA0, 1, 1, 1,  32'h101, 3'd1};
    tv[5]  = '{1, 1,  32'h102, 1, 11, 32'hA1, 1, 1, 1,  32'h102, 3'd2};
    tv[6]  = '{1, 1,  32'h103, 1, 12, 32'hA2, 0, 1, 1,  32'h103, 3'd2};
    tv[7]  = '{0, 0,  32'h0,   1, 12, 32'hA2, 0, 1, 10, 32'hA0,  3'd1};
    tv[8]  = '{0, 0,  32'h0,   1, 12, 32'hA2, 1, 1, 11, 32'hA1,  3'd1};
    tv[9]  = '{0, 0,  32'h0,   0, 0,  32'h0,  1, 1, 12, 32'hA2,  3'd0};
    tv[10] = '{1, 2,  32'h22,  1, 9,  32'h1,  1, 1, 2,  32'h22,  3'd1};
    tv[11] = '{1, 9,  32'h2,   0, 0,  32'h0,  1, 1, 9,  32'h2,   3'd0};
    tv[12] = '{0, 0,  32'h0,   0, 0,  32'h0,  1, 0, 9,  32'h2,   3'd0};
    tv[13] = '{1, 4,  32'h44,  1, 4,  32'h99, 1, 1, 4,  32'h44,  3'd0};
    tv[14] = '{0, 0,  32'h0,   0, 0,  32'h0,  1, 0, 4,  32'h44,  3'd0};
    tv[15] = '{1, 0,  32'h55,  1, 0,  32'h66, 1, 0, 4,  32'h44,  3'd0};
    tv[16] = '{1, 0,  32'h55,  1, 0,  32'h66, 1, 0, 4,  32'h44,  3'd0};
    tv[17] = '{1, 0,  32'h58,  1, 6,  32'h77, 1, 1, 6,  32'h77,  3'd0};
    tv[18] = '{0, 0,  32'h0,   0, 0,  32'h0,  1, 0, 6,  32'h77,  3'd0};

    // Reset state.
    #12;
    chk("rst_WE", {31'd0, WE}, 32'd0);
    chk("rst_WeSel", {27'd0, WeSel}, 32'd0);
    chk("rst_WData", WData, 32'd0);
    chk("rst_buf_count", {29'd0, buf_count}, 32'd0);
    chk("rst_md_ready", {31'd0, md_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    foreach (tv[i]) begin
      cyc(tv[i].av, tv[i].as, tv[i].ad, tv[i].mv, tv[i].ms, tv[i].md);
      chk($sformatf("tv%0d_rdy", i), {31'd0, got_rdy}, {31'd0, tv[i].rdy});
      chk($sformatf("tv%0d_WE", i), {31'd0, WE}, {31'd0, tv[i].we});
      chk($sformatf("tv%0d_WeSel", i), {27'd0, WeSel}, {27'd0, tv[i].sel});
      chk($sformatf("tv%0d_WData", i), WData, tv[i].data);
      chk($sformatf("tv%0d_cnt", i), {29'd0, buf_count}, {29'd0, tv[i].cnt});
    end

    // Reset mid-operation with two buffered results.
    cyc(1, 1, 32'h201, 1, 13, 32'hB0);
    cyc(1, 1, 32'h202, 1, 14, 32'hB1);
    chk("pre_rst_cnt", {29'd0, buf_count}, 32'd2);
    alu_valid = 0; md_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_WE", {31'd0, WE}, 32'd0);
    chk("mid_rst_WeSel", {27'd0, WeSel}, 32'd0);
    chk("mid_rst_WData", WData, 32'd0);
    chk("mid_rst_cnt", {29'd0, buf_count}, 32'd0);
    chk("mid_rst_md_ready", {31'd0, md_ready}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("hold_rst_WE", {31'd0, WE}, 32'd0);
    chk("hold_rst_md_ready", {31'd0, md_ready}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    mq.delete(); e_we = 1'b0; e_sel = '0; e_data = '0;
    repeat (3) begin
      cyc(0, 0, 32'h0, 0, 0, 32'h0);
      chk("post_rst_no_stale_WE", {31'd0, WE}, 32'd0);
    end

    // Randomized traffic with narrow select ranges to force squash/R0 cases.
    repeat (600) begin
      cyc(($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom,
          ($urandom_range(0, 99) < 60), 5'($urandom_range(0, 7)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
